// File: rtl/seg7_scan_driver.sv
// Multiplexed BCD seven-segment scan driver: one digit lit per interval, one dark cycle between digits.
// Optional leading-zero blanking is compiled in with `define SEG7_LZ_BLANK_EN.
module seg7_scan_driver #(
    parameter int DIGITS  = 4,
    parameter int CLK_DIV = 50000
) (
    input  logic                Clock,
    input  logic                Resetn,
    input  logic                Load,
    input  logic [4*DIGITS-1:0] Digits,
    output logic [1:7]          Seg,
    output logic [DIGITS-1:0]   Dig_sel,
    output logic                Frame
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    typedef enum logic {GAP = 1'b0, SHOW = 1'b1} state_t;

    state_t              state;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       idx_next;
    logic [CW-1:0]       cnt;
    logic [4*DIGITS-1:0] disp;
    logic [3:0]          digit_next;
    logic [DIGITS-1:0]   sel_next;
    logic [1:7]          seg_next;
    logic                blank_next;
`ifdef SEG7_LZ_BLANK_EN
    logic                zero_run;
`endif

    function automatic logic [1:7] decode(input logic [3:0] bcd);
        logic [1:7] s;
        case (bcd)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Everything below looks at the digit that the next SHOW entry will light,
    // using the display register as it stands before this edge's Load.
    always_comb begin
        idx_next   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        digit_next = '0;
        sel_next   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_next == IW'(i)) begin
                digit_next  = disp[4*i +: 4];
                sel_next[i] = 1'b1;
            end
        end
        blank_next = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
        // Walk down from the top digit; a digit is blanked while every digit above it is zero too.
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (disp[4*i +: 4] == 4'd0);
            if (sel_next[i] && zero_run)
                blank_next = 1'b1;
        end
`endif
        seg_next = blank_next ? '0 : decode(digit_next);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state   <= GAP;
            idx     <= IDX_LAST;
            cnt     <= '0;
            disp    <= '0;
            Seg     <= '0;
            Dig_sel <= '0;
            Frame   <= 1'b0;
        end else begin
            if (Load)
                disp <= Digits;
            case (state)
                GAP: begin
                    state   <= SHOW;
                    idx     <= idx_next;
                    cnt     <= '0;
                    Dig_sel <= sel_next;
                    Seg     <= seg_next;
                    Frame   <= (idx_next == '0);
                end
                SHOW: begin
                    Frame <= 1'b0;
                    if (cnt == CNT_LAST) begin
                        state   <= GAP;
                        cnt     <= '0;
                        Dig_sel <= '0;
                        Seg     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= GAP;
            endcase
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: stimulus queues the expected digit presentations, a negedge monitor pops and checks them.
module tb_seg7_scan_driver;
    localparam logic [6:0] S0 = 7'b1111110;
    localparam logic [6:0] S1 = 7'b0110000;
    localparam logic [6:0] S2 = 7'b1101101;
    localparam logic [6:0] S3 = 7'b1111001;
    localparam logic [6:0] S4 = 7'b0110011;
    localparam logic [6:0] S5 = 7'b1011011;
    localparam logic [6:0] S7 = 7'b1110000;
    localparam logic [6:0] S9 = 7'b1111011;
    localparam logic [6:0] SZ = 7'b0000000;
`ifdef SEG7_LZ_BLANK_EN
    localparam logic [6:0] ZB = SZ;
`else
    localparam logic [6:0] ZB = S0;
`endif

    logic        Clock = 1'b0;
    logic        Resetn, Resetn1, Load, Load1;
    logic [15:0] Digits;
    logic [3:0]  Digits1;
    logic [1:7]  Seg, Seg1;
    logic [3:0]  Dig_sel;
    logic [0:0]  Dig_sel1;
    logic        Frame, Frame1;

    seg7_scan_driver #(.DIGITS(4), .CLK_DIV(4)) u_dut (
        .Clock(Clock), .Resetn(Resetn), .Load(Load), .Digits(Digits),
        .Seg(Seg), .Dig_sel(Dig_sel), .Frame(Frame)
    );

    seg7_scan_driver #(.DIGITS(1), .CLK_DIV(2)) u_dut1 (
        .Clock(Clock), .Resetn(Resetn1), .Load(Load1), .Digits(Digits1),
        .Seg(Seg1), .Dig_sel(Dig_sel1), .Frame(Frame1)
    );

    initial forever #5 Clock = ~Clock;

    typedef struct packed {
        logic [3:0] sel;
        logic [6:0] seg;
        logic       frame;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Edge counter since reset release: cyc == k right after posedge k.
    always @(posedge Clock) begin
        if (!Resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] s, input logic [6:0] g, input logic f);
        return {s, g, f};
    endfunction

    // Monitor state, one slot per DUT instance.
    logic       in_show[2]    = '{1'b0, 1'b0};
    logic       seen_show[2]  = '{1'b0, 1'b0};
    logic       seen_frame[2] = '{1'b0, 1'b0};
    int         show_len[2]   = '{0, 0};
    int         gap_len[2]    = '{0, 0};
    int         since_fr[2]   = '{0, 0};
    logic [3:0] cur_sel[2];
    logic [6:0] cur_seg[2];

    task automatic mon(input int ch, input logic [3:0] sel, input logic [6:0] sg,
                       input logic fr, input logic rstn);
        exp_t e;
        int   cdiv;
        int   fper;
        cdiv = (ch == 0) ? 4 : 2;
        fper = (ch == 0) ? 20 : 3;
        if (!rstn) begin
            in_show[ch]    = 1'b0;
            seen_show[ch]  = 1'b0;
            seen_frame[ch] = 1'b0;
            gap_len[ch]    = 0;
            return;
        end
        since_fr[ch]++;
        if (fr) begin
            if (seen_frame[ch]) chk($sformatf("ch%0d frame period", ch), since_fr[ch], fper);
            since_fr[ch]   = 0;
            seen_frame[ch] = 1'b1;
        end
        if (sel != 4'd0) begin
            if (!in_show[ch]) begin
                if (seen_show[ch]) chk($sformatf("ch%0d gap length", ch), gap_len[ch], 1);
                if ((ch == 0 && q0.size() == 0) || (ch == 1 && q1.size() == 0)) begin
                    checks++;
                    errors++;
                    $display("FAIL ch%0d entry: got sel=%0h seg=%b frame=%0b, expected no entry", ch, sel, sg, fr);
                end else begin
                    e = (ch == 0) ? q0.pop_front() : q1.pop_front();
                    chk($sformatf("ch%0d entry {sel,seg,frame}", ch), {sel, sg, fr}, e);
                end
                in_show[ch]  = 1'b1;
                show_len[ch] = 1;
                cur_sel[ch]  = sel;
                cur_seg[ch]  = sg;
            end else begin
                show_len[ch]++;
                chk($sformatf("ch%0d hold {sel,seg,frame}", ch), {sel, sg, fr}, {cur_sel[ch], cur_seg[ch], 1'b0});
            end
        end else begin
            if (in_show[ch]) begin
                chk($sformatf("ch%0d show length", ch), show_len[ch], cdiv);
                in_show[ch]   = 1'b0;
                seen_show[ch] = 1'b1;
                gap_len[ch]   = 0;
            end
            gap_len[ch]++;
            chk($sformatf("ch%0d dark {seg,frame}", ch), {sg, fr}, 8'h00);
        end
    endtask

    always @(negedge Clock) begin
        mon(0, Dig_sel, Seg, Frame, Resetn);
        mon(1, {3'b000, Dig_sel1}, Seg1, Frame1, Resetn1);
    end

    // Load value v so it is captured at posedge k.
    task automatic load_at(input int k, input logic [15:0] v);
        wait (cyc == k - 1);
        @(negedge Clock); #1;
        Load = 1'b1;
        Digits = v;
        @(negedge Clock); #1;
        Load = 1'b0;
    endtask

    initial begin
        Resetn = 1'b1; Resetn1 = 1'b1;
        Load = 1'b0; Load1 = 1'b0;
        Digits = '0; Digits1 = '0;
        #1 Resetn = 1'b0; Resetn1 = 1'b0;
        #2;
        chk("reset Seg", Seg, 0);
        chk("reset Dig_sel", Dig_sel, 0);
        chk("reset Frame", Frame, 0);
        chk("reset Dig_sel1", Dig_sel1, 0);

        // Load of 4321 on the first edge is too late for that edge's digit 0.
        q0.push_back(mk(4'b0001, S0, 1'b1));
        q0.push_back(mk(4'b0010, S2, 1'b0));
        q0.push_back(mk(4'b0100, S3, 1'b0));
        q0.push_back(mk(4'b1000, S4, 1'b0));
        q0.push_back(mk(4'b0001, S1, 1'b1));
        q0.push_back(mk(4'b0010, S2, 1'b0));
        q0.push_back(mk(4'b0100, S3, 1'b0));
        q0.push_back(mk(4'b1000, S4, 1'b0));
        q0.push_back(mk(4'b0001, S1, 1'b1));
        q0.push_back(mk(4'b0010, S2, 1'b0));   // 9999 loaded mid-interval
        q0.push_back(mk(4'b0100, S9, 1'b0));
        q0.push_back(mk(4'b1000, S9, 1'b0));
        q0.push_back(mk(4'b0001, S9, 1'b1));   // FA00 loaded mid-interval
        q0.push_back(mk(4'b0010, S0, 1'b0));
        q0.push_back(mk(4'b0100, SZ, 1'b0));
        q0.push_back(mk(4'b1000, SZ, 1'b0));
        q0.push_back(mk(4'b0001, S0, 1'b1));   // 0050 loaded mid-interval
        q0.push_back(mk(4'b0010, S5, 1'b0));
        q0.push_back(mk(4'b0100, ZB, 1'b0));
        q0.push_back(mk(4'b1000, ZB, 1'b0));
        q0.push_back(mk(4'b0001, S0, 1'b1));
        q0.push_back(mk(4'b0010, S5, 1'b0));
        q1.push_back(mk(4'b0001, S0, 1'b1));
        for (int i = 0; i < 4; i++) q1.push_back(mk(4'b0001, S7, 1'b1));

        repeat (3) @(negedge Clock);
        #1;
        Resetn = 1'b1; Resetn1 = 1'b1;
        Load = 1'b1; Digits = 16'h4321;
        Load1 = 1'b1; Digits1 = 4'd7;
        @(negedge Clock); #1;
        Load = 1'b0; Load1 = 1'b0;

        wait (cyc == 14);
        @(negedge Clock); #1;
        Resetn1 = 1'b0;

        load_at(47, 16'h9999);
        load_at(63, 16'hFA00);
        load_at(83, 16'h0050);

        // Asynchronous reset in the middle of digit 1; the concurrent Load must be lost.
        wait (cyc == 107);
        #2;
        Resetn = 1'b0;
        Load = 1'b1;
        Digits = 16'h8888;
        #1;
        chk("async reset Seg", Seg, 0);
        chk("async reset Dig_sel", Dig_sel, 0);
        chk("async reset Frame", Frame, 0);
        q0.push_back(mk(4'b0001, S0, 1'b1));
        q0.push_back(mk(4'b0010, ZB, 1'b0));
        q0.push_back(mk(4'b0100, ZB, 1'b0));
        q0.push_back(mk(4'b1000, ZB, 1'b0));
        q0.push_back(mk(4'b0001, S0, 1'b1));
        repeat (2) @(negedge Clock);
        #1 Load = 1'b0;
        @(negedge Clock); #1;
        Resetn = 1'b1;

        wait (cyc == 23);
        for (int i = 0; i < 100 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge Clock);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d expected entries left, expected 0/0", q0.size(), q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of BCD digits driven, legal range 1..8.
REQ-002 SHALL have parameter CLK_DIV, default 50000: Clock cycles each digit is lit, legal range 2..2^20.
REQ-003 SHALL have port Clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Resetn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port Load  input  1  capture Digits into the display register on this edge.
REQ-006 SHALL have port Digits  input  4*DIGITS  packed BCD; Digits[3:0] is digit 0 (least significant).
REQ-007 SHALL have port Seg  output  [1:7]  segments abcdefg, active-high, Seg[1]=a.
REQ-008 SHALL have port Dig_sel  output  DIGITS  one-hot digit enable, active-high; bit i lights digit i.
REQ-009 SHALL have port Frame  output  1  one-cycle pulse when a scan of all digits starts.

Function
REQ-010 SHALL be a two-state FSM: GAP (all digits off) and SHOW (one digit lit); scan index idx ranges 0..DIGITS-1.
REQ-011 SHALL drive Seg, Dig_sel and Frame from registers only.
REQ-012 SHALL go GAP->SHOW on every edge while in GAP, with idx <= (idx==DIGITS-1) ? 0 : idx+1; GAP lasts exactly one cycle.
REQ-013 SHALL count prescaler cnt 0..CLK_DIV-1 while in SHOW; on the edge where cnt==CLK_DIV-1, go SHOW->GAP and clear cnt.
REQ-014 SHALL hold each digit lit for exactly CLK_DIV cycles, then dark for 1 cycle; full frame = DIGITS*(CLK_DIV+1) cycles.
REQ-015 SHALL, in GAP, drive Dig_sel=0 and Seg=0 (anti-ghosting interval).
REQ-016 SHALL, on entering SHOW, load Dig_sel with bit idx set, and Seg with the decode of display digit idx; both are held constant for the whole SHOW interval.
REQ-017 SHALL decode 0..9 as: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
REQ-018 SHALL decode the non-BCD codes 10..15 to Seg=0000000; the output never carries X.
REQ-019 SHALL capture Digits into the display register on any edge with Load=1, in either state; the last Load wins.
REQ-020 SHALL apply a new display value only at the next SHOW entry; the currently lit digit is never changed mid-interval.
REQ-021 SHALL, for a Load on the same edge as SHOW entry, decode the old register value for that entry.
REQ-022 SHALL assert Frame for exactly the one cycle in which SHOW with idx=0 is entered.
REQ-023 SHALL, with DIGITS=1, still cycle GAP/SHOW; Dig_sel[0] SHALL be low during GAP.

Reset
REQ-024 SHALL, while Resetn=0 and independent of Clock, force state=GAP, idx=DIGITS-1, cnt=0, display register=0, Seg=0, Dig_sel=0, Frame=0.
REQ-025 SHALL, on the first edge after Resetn rises, enter SHOW with idx=0 and assert Frame.
REQ-026 SHALL abandon the current scan when reset is asserted mid-SHOW; outputs go dark immediately and a Load in progress is lost.

Configuration
REQ-027 SHALL support macro SEG7_LZ_BLANK_EN (leading-zero blanking).
REQ-028 SHALL, when SEG7_LZ_BLANK_EN is defined, blank digit i>0 (Seg=0, Dig_sel bit still asserted) if digit i and all higher digits are 0.
REQ-029 SHALL never blank digit 0 under SEG7_LZ_BLANK_EN.
REQ-030 SHALL, when SEG7_LZ_BLANK_EN is undefined, display every digit, zeros included.

Verification (DIGITS=4, CLK_DIV=4 unless stated)
REQ-031 SHALL cover reset: Resetn low mid-SHOW -> Seg=0, Dig_sel=0, Frame=0 with no clock edge; release -> next edge Dig_sel=0001, Frame=1.
REQ-032 SHALL cover scan timing: Load Digits=16'h4321 -> Dig_sel 0001/0010/0100/1000 each 4 cycles, 1-cycle 0000 between, Seg 0110000,1101101,1111001,0110011; Frame period 20 cycles.
REQ-033 SHALL cover tear-free update: Load 16'h9999 during digit 1 SHOW -> Seg unchanged until GAP; digit 2 shows 1111011.
REQ-034 SHALL cover non-BCD input: Digits=16'hFA00 -> digits 2,3 give Seg=0000000, digits 0,1 give 1111110.
REQ-035 SHALL cover blanking: Digits=16'h0050 with SEG7_LZ_BLANK_EN -> digits 3,2 Seg=0, digit 1=1011011, digit 0=1111110; without the macro, digits 3,2=1111110.
REQ-036 SHALL cover boundary cases: DIGITS=1, CLK_DIV=2 -> Dig_sel pattern 1,1,0 repeating, Frame every 3 cycles.
